// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer and flag controller for an asynchronous FIFO.
// Optional macro FIFO_WR_LEVEL_EN adds the registered wr_level output.
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic                  wr_overflow
`ifdef FIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wr_level
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_THRESH);

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] level_next;
    logic [ADDR_WIDTH:0] full_ptr;

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b = '0;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int unsigned j = 0; j < ADDR_WIDTH; j++) begin
            b[ADDR_WIDTH-1-j] = b[ADDR_WIDTH-j] ^ g[ADDR_WIDTH-1-j];
        end
        return b;
    endfunction

    assign wclken = wr_en & ~wfull;
    assign waddr  = wbin[ADDR_WIDTH-1:0];

    always_comb begin
        wbin_next  = wbin + (ADDR_WIDTH + 1)'(wclken);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = gray2bin(wq2_rptr);
        level_next = wbin_next - rbin;
        // Full: write pointer is exactly one lap ahead of the synchronized read pointer.
        full_ptr   = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wr_overflow  <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_ptr);
            walmost_full <= (level_next >= AF_LEVEL);
            wr_overflow  <= wr_en & wfull;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_level <= '0;
        end else begin
            wr_level <= level_next;
        end
    end
`endif

endmodule
